// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared types and constants for the SPI command sequencer: FSM states,
// control-register bit layout and register-select encodings.
package pkg_global;

  localparam int bits_n = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CTRL = 3'd2,
    POLL = 3'd3,
    READ = 3'd4,
    DONE = 3'd5
  } seq_state_e;

  localparam int SEND_BIT = 0;
  localparam int CS_BIT   = 1;
  localparam int ALL1_BIT = 2;
  localparam int ALL0_BIT = 3;
  localparam int NTX_LSB  = 4;
  localparam int NTX_MSB  = 12;
  localparam int NRX_LSB  = 16;
  localparam int NRX_MSB  = 25;
  localparam int NTX_W    = NTX_MSB - NTX_LSB + 1;

  localparam logic REG_SEL_CTRL = 1'b0;
  localparam logic REG_SEL_DATA = 1'b1;

  // Control word that starts a transmit-only burst of n_tx_end+1 bytes.
  function automatic logic [31:0] make_ctrl(input logic [NTX_W-1:0] n_tx_end);
    logic [31:0] w;
    w                   = '0;
    w[SEND_BIT]         = 1'b1;
    w[CS_BIT]           = 1'b1;
    w[ALL1_BIT]         = 1'b0;
    w[ALL0_BIT]         = 1'b0;
    w[NTX_MSB:NTX_LSB]  = n_tx_end;
    w[NRX_MSB:NRX_LSB]  = '0;
    return w;
  endfunction

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// Bundle of the sequencer's command, byte-stream and SPI-register signals.
interface spi_cmd_sequencer_if #(
  parameter int ADDR_W = pkg_global::bits_n
) ();
  import pkg_global::*;

  // Streams use valid/ready: a byte moves on a rising edge where both are 1;
  // the source holds valid and data stable until that edge.
  logic              start_i;
  logic [ADDR_W-1:0] len_i;
  logic              tx_valid_i;
  logic [7:0]        tx_data_i;
  logic              tx_ready_o;
  logic              rx_valid_o;
  logic [7:0]        rx_data_o;
  logic              rx_ready_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic              spi_we_o;
  logic              spi_reg_sel_o;
  logic [ADDR_W-1:0] spi_addr_o;
  logic [31:0]       spi_wdata_o;
  logic [31:0]       spi_rdata_i;
  seq_state_e        state_dbg_o;

  modport slave (
    input  start_i, len_i, tx_valid_i, tx_data_i, rx_ready_i, spi_rdata_i,
    output tx_ready_o, rx_valid_o, rx_data_o, busy_o, done_o, err_o,
           spi_we_o, spi_reg_sel_o, spi_addr_o, spi_wdata_o, state_dbg_o
  );

  modport master (
    output start_i, len_i, tx_valid_i, tx_data_i, rx_ready_i, spi_rdata_i,
    input  tx_ready_o, rx_valid_o, rx_data_o, busy_o, done_o, err_o,
           spi_we_o, spi_reg_sel_o, spi_addr_o, spi_wdata_o, state_dbg_o
  );

endinterface

// File: rtl/spi_cmd_sequencer_timeout.sv
// Saturating cycle counter used to bound the time spent polling the SPI core.
module module_seq_timeout #(
  parameter int MAX_CNT = 65535,
  parameter int W       = $clog2(MAX_CNT + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         expired_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && count_q != W'(MAX_CNT)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o   = count_q;
  assign expired_o = (count_q == W'(MAX_CNT));

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Loads a byte burst into the SPI data RAM, kicks the control register,
// polls for completion, then streams the received bytes back out.
module spi_cmd_sequencer
  import pkg_global::*;
#(
  parameter int ADDR_W      = bits_n,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                clk_i,
  input  logic                rst_i,
  spi_cmd_sequencer_if.slave  bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] len_q, idx_q;
  logic              err_q, rx_valid_q;
  logic [7:0]        rx_data_q;
  logic [TMO_W-1:0]  poll_cnt;
  logic              tmo_expired;
  logic              last_byte, send_clear, timeout_hit;

  logic              tx_ready_d, we_d, sel_d, done_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d;
  logic              unused_rdata;

  assign last_byte   = (idx_q == len_q - ADDR_W'(1));
  // The first POLL cycle (count 0) still sees the stale control register.
  assign send_clear  = (state_q == POLL) && (poll_cnt != '0) && !bus.spi_rdata_i[SEND_BIT];
  assign timeout_hit = (state_q == POLL) && tmo_expired && !send_clear;
  assign unused_rdata = ^bus.spi_rdata_i[31:8];

  module_seq_timeout #(.MAX_CNT(TIMEOUT_CYC), .W(TMO_W)) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (state_q != POLL),
    .en_i      (state_q == POLL),
    .count_o   (poll_cnt),
    .expired_o (tmo_expired)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    tx_ready_d = 1'b0;
    we_d       = 1'b0;
    sel_d      = REG_SEL_CTRL;
    addr_d     = '0;
    wdata_d    = '0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: if (bus.start_i && bus.len_i != '0) state_d = LOAD;
      LOAD: begin
        tx_ready_d = 1'b1;
        sel_d      = REG_SEL_DATA;
        addr_d     = idx_q;
        if (bus.tx_valid_i) begin
          we_d    = 1'b1;
          wdata_d = {24'h0, bus.tx_data_i};
          if (last_byte) state_d = CTRL;
        end
      end
      CTRL: begin
        we_d    = 1'b1;
        wdata_d = make_ctrl(NTX_W'(len_q - ADDR_W'(1)));
        state_d = POLL;
      end
      POLL: begin
        if (send_clear) begin
          state_d = READ;
        end else if (timeout_hit) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      READ: begin
        sel_d  = REG_SEL_DATA;
        addr_d = idx_q;
        if (rx_valid_q && bus.rx_ready_i && last_byte) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      len_q      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            if (bus.len_i != '0) begin
              len_q <= bus.len_i;
              idx_q <= '0;
              err_q <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: if (bus.tx_valid_i) idx_q <= last_byte ? '0 : idx_q + ADDR_W'(1);
        POLL: begin
          if (send_clear)       idx_q <= '0;
          else if (timeout_hit) err_q <= 1'b1;
        end
        READ: begin
          // Capture one cycle after the address is presented; hold until taken.
          if (!rx_valid_q) begin
            rx_data_q  <= bus.spi_rdata_i[7:0];
            rx_valid_q <= 1'b1;
          end else if (bus.rx_ready_i) begin
            rx_valid_q <= 1'b0;
            if (!last_byte) idx_q <= idx_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.tx_ready_o    = tx_ready_d;
  assign bus.rx_valid_o    = rx_valid_q;
  assign bus.rx_data_o     = rx_data_q;
  assign bus.busy_o        = (state_q != IDLE);
  assign bus.done_o        = done_d;
  assign bus.err_o         = err_q;
  assign bus.spi_we_o      = we_d;
  assign bus.spi_reg_sel_o = sel_d;
  assign bus.spi_addr_o    = addr_d;
  assign bus.spi_wdata_o   = wdata_d;
  assign bus.state_dbg_o   = state_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer: SPI register model, byte-stream drivers and a
// queue scoreboard built from the transaction-level rules.
module tb_spi_cmd_sequencer;
  import pkg_global::*;

  localparam int ADDR_W = 8;
  localparam int WR_W   = ADDR_W + 32;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  spi_cmd_sequencer_if #(.ADDR_W(ADDR_W)) bus   ();
  spi_cmd_sequencer_if #(.ADDR_W(ADDR_W)) bus_t ();

  spi_cmd_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(65535)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  spi_cmd_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(16)) dut_tmo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_t)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- SPI core model ----------------
  logic [7:0] rx_mem [256];
  logic       send_q    = 1'b0;
  int         send_left = 0;
  int         poll_delay = 1;

  always @(posedge clk_i) begin
    if (bus.spi_we_o && bus.spi_reg_sel_o == REG_SEL_CTRL && bus.spi_wdata_o[SEND_BIT]) begin
      send_q    <= 1'b1;
      send_left <= poll_delay;
    end else if (send_q) begin
      if (send_left <= 1) send_q <= 1'b0;
      send_left <= send_left - 1;
    end
  end

  assign bus.spi_rdata_i   = (bus.spi_reg_sel_o == REG_SEL_DATA) ?
                             {24'h0, rx_mem[bus.spi_addr_o]} : {31'h0, send_q};
  assign bus_t.spi_rdata_i = 32'h1;

  // ---------------- scoreboard ----------------
  logic [WR_W-1:0] exp_wr_q[$];
  logic [31:0]     exp_ctrl_q[$];
  logic [7:0]      exp_rx_q[$];
  int rx_cnt   = 0;
  int we_cnt   = 0;
  int done_cnt = 0;

  logic [7:0] tx_pat [256];
  logic [7:0] rx_pat [256];

  always @(negedge clk_i) begin
    if (rst_i) begin
      if (bus.spi_we_o) begin
        we_cnt++;
        if (bus.spi_reg_sel_o == REG_SEL_DATA) begin
          if (exp_wr_q.size() == 0) check("wr_unexpected", 1, 0);
          else check("wr_data", {bus.spi_addr_o, bus.spi_wdata_o}, exp_wr_q.pop_front());
        end else begin
          if (exp_ctrl_q.size() == 0) check("ctrl_unexpected", 1, 0);
          else check("ctrl_word", bus.spi_wdata_o, exp_ctrl_q.pop_front());
        end
      end
      if (bus.rx_valid_o) begin
        if (exp_rx_q.size() == 0) begin
          check("rx_unexpected", 1, 0);
        end else begin
          check("rx_data", bus.rx_data_o, exp_rx_q[0]);
          check("rx_addr", bus.spi_addr_o, rx_cnt);
          if (bus.rx_ready_i) begin
            void'(exp_rx_q.pop_front());
            rx_cnt++;
          end
        end
      end
      if (bus.done_o) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_tx_ready"}, bus.tx_ready_o, 0);
    check({pfx, "_rx_valid"}, bus.rx_valid_o, 0);
    check({pfx, "_busy"},     bus.busy_o, 0);
    check({pfx, "_done"},     bus.done_o, 0);
    check({pfx, "_err"},      bus.err_o, 0);
    check({pfx, "_we"},       bus.spi_we_o, 0);
    check({pfx, "_reg_sel"},  bus.spi_reg_sel_o, 0);
    check({pfx, "_addr"},     bus.spi_addr_o, 0);
    check({pfx, "_wdata"},    bus.spi_wdata_o, 0);
    check({pfx, "_rx_data"},  bus.rx_data_o, 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int cyc;
    bit hs;
    repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
    bus.tx_valid_i = 1'b1;
    bus.tx_data_i  = b;
    cyc = 0;
    hs  = 1'b0;
    while (!hs && cyc < 50) begin
      @(negedge clk_i);
      hs = bus.tx_ready_o;
      @(posedge clk_i); #1;
      cyc++;
    end
    if (!hs) check("tx_hs_timeout", 0, 1);
    bus.tx_valid_i = 1'b0;
    bus.tx_data_i  = 8'($urandom);
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) begin
      tx_pat[i] = 8'($urandom);
      rx_pat[i] = 8'($urandom);
    end
  endtask

  // Reference: len data writes at addr i, one control word, len rx bytes, one done.
  task automatic run_txn(input int len, input int delay, input int stall_byte, input bit poke_start);
    int  cyc;
    int  stall;
    int  done0;
    bit  got_done;
    for (int i = 0; i < len; i++) begin
      exp_wr_q.push_back({ADDR_W'(i), 24'h0, tx_pat[i]});
      exp_rx_q.push_back(rx_pat[i]);
      rx_mem[i] = rx_pat[i];
    end
    exp_ctrl_q.push_back(32'h3 | (32'(len - 1) << 4));
    poll_delay = delay;
    rx_cnt     = 0;
    done0      = done_cnt;

    bus.start_i = 1'b1;
    bus.len_i   = ADDR_W'(len);
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    bus.len_i   = ADDR_W'($urandom);
    check("busy_after_start", bus.busy_o, 1);
    for (int i = 0; i < len; i++) send_byte(tx_pat[i]);

    cyc      = 0;
    stall    = 0;
    got_done = 1'b0;
    while (!got_done && cyc < len * 8 + delay + 200) begin
      if (stall_byte >= 0 && rx_cnt == stall_byte && bus.rx_valid_o && stall < 5) begin
        bus.rx_ready_i = 1'b0;
        stall++;
      end else begin
        bus.rx_ready_i = ($urandom_range(0, 3) != 0);
      end
      if (poke_start && rx_cnt == 1) begin
        bus.start_i = 1'b1;
        bus.len_i   = ADDR_W'($urandom_range(1, 5));
      end else begin
        bus.start_i = 1'b0;
      end
      @(negedge clk_i);
      got_done = bus.done_o;
      @(posedge clk_i); #1;
      cyc++;
    end
    bus.start_i    = 1'b0;
    bus.rx_ready_i = 1'b0;
    check("done_seen", got_done, 1);
    check("done_one_cycle", bus.done_o, 0);
    check("busy_after_done", bus.busy_o, 0);
    check("err_after_done", bus.err_o, 0);
    check("done_count", done_cnt - done0, 1);
    check("wr_left", exp_wr_q.size(), 0);
    check("ctrl_left", exp_ctrl_q.size(), 0);
    check("rx_left", exp_rx_q.size(), 0);
    exp_wr_q.delete();
    exp_ctrl_q.delete();
    exp_rx_q.delete();
    repeat (2) begin @(posedge clk_i); #1; end
    check("idle_after_txn", bus.busy_o, 0);
  endtask

  task automatic run_reset_mid_load();
    int we0;
    for (int i = 0; i < 2; i++) begin
      tx_pat[i] = 8'($urandom);
      exp_wr_q.push_back({ADDR_W'(i), 24'h0, tx_pat[i]});
    end
    bus.start_i = 1'b1;
    bus.len_i   = ADDR_W'(4);
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    send_byte(tx_pat[0]);
    send_byte(tx_pat[1]);
    bus.tx_valid_i = 1'b1;
    bus.tx_data_i  = 8'($urandom);
    #2;
    rst_i = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    we0 = we_cnt;
    repeat (10) begin
      @(posedge clk_i); #1;
      bus.tx_valid_i = 1'($urandom);
      bus.tx_data_i  = 8'($urandom);
    end
    bus.tx_valid_i = 1'b0;
    check("rst_no_we_after", we_cnt - we0, 0);
    check("rst_wr_left", exp_wr_q.size(), 0);
    check("rst_busy_after", bus.busy_o, 0);
    exp_wr_q.delete();
  endtask

  task automatic run_len_zero();
    int we0;
    we0 = we_cnt;
    bus.start_i = 1'b1;
    bus.len_i   = '0;
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    check("len0_err", bus.err_o, 1);
    check("len0_busy", bus.busy_o, 0);
    repeat (4) begin
      @(posedge clk_i); #1;
      check("len0_busy_hold", bus.busy_o, 0);
    end
    check("len0_err_sticky", bus.err_o, 1);
    check("len0_no_we", we_cnt - we0, 0);
  endtask

  // Error and done expected on the 17th POLL cycle (poll count reaches 16).
  task automatic run_timeout();
    int cyc;
    bit seen;
    bus_t.start_i = 1'b1;
    bus_t.len_i   = ADDR_W'(1);
    @(posedge clk_i); #1;
    bus_t.start_i    = 1'b0;
    bus_t.tx_valid_i = 1'b1;
    bus_t.tx_data_i  = 8'($urandom);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk_i);
      seen = bus_t.spi_we_o && (bus_t.spi_reg_sel_o == REG_SEL_CTRL);
      cyc++;
    end
    check("tmo_ctrl_seen", seen, 1);
    bus_t.tx_valid_i = 1'b0;
    if (seen) begin
      check("tmo_ctrl_word", bus_t.spi_wdata_o, 32'h3);
      for (int n = 1; n <= 20; n++) begin
        @(negedge clk_i);
        check($sformatf("tmo_done_%0d", n), bus_t.done_o, (n == 17));
        check($sformatf("tmo_err_%0d", n),  bus_t.err_o,  (n > 17));
        check($sformatf("tmo_busy_%0d", n), bus_t.busy_o, (n <= 17));
      end
    end
    @(posedge clk_i); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.start_i      = 1'b0;
    bus.len_i        = '0;
    bus.tx_valid_i   = 1'b0;
    bus.tx_data_i    = '0;
    bus.rx_ready_i   = 1'b0;
    bus_t.start_i    = 1'b0;
    bus_t.len_i      = '0;
    bus_t.tx_valid_i = 1'b0;
    bus_t.tx_data_i  = '0;
    bus_t.rx_ready_i = 1'b1;
    for (int i = 0; i < 256; i++) rx_mem[i] = '0;

    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("reset");
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    tx_pat[0] = 8'hA5; tx_pat[1] = 8'h3C; tx_pat[2] = 8'hFF;
    rx_pat[0] = 8'h11; rx_pat[1] = 8'h22; rx_pat[2] = 8'h33;
    run_txn(3, 20, -1, 1'b0);

    run_reset_mid_load();
    run_len_zero();

    fill_random(4);
    run_txn(4, $urandom_range(1, 30), 1, 1'b0);
    fill_random(4);
    run_txn(4, $urandom_range(1, 30), -1, 1'b1);

    fill_random(1);
    run_txn(1, 1, -1, 1'b0);
    fill_random(255);
    run_txn(255, $urandom_range(1, 30), -1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      int len;
      len = $urandom_range(1, 20);
      fill_random(len);
      run_txn(len, $urandom_range(1, 30), -1, 1'b0);
    end

    run_timeout();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/spi_cmd_sequencer.md
SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: data-RAM address width of the SPI interface; equals the width of pkg_global::bits_n.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 65535: maximum cycles spent in POLL before an error is raised.
REQ-003 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous assert, active-low.
REQ-005 start_i  in  1  starts one transaction; sampled only in IDLE.
REQ-006 len_i  in  ADDR_W  byte count, valid range 1..2^ADDR_W-1; captured with start_i.
REQ-007 tx_valid_i / tx_data_i[7:0] / tx_ready_o  in/in/out  byte stream to transmit, valid/ready.
REQ-008 rx_valid_o / rx_data_o[7:0] / rx_ready_i  out/out/in  byte stream received, valid/ready.
REQ-009 busy_o, done_o, err_o  out  1 each  not-IDLE level; 1-cycle completion pulse; sticky error.
REQ-010 spi_we_o, spi_reg_sel_o  out  1 each  write strobe and select (0 = control register, 1 = data RAM) to the SPI interface.
REQ-011 spi_addr_o  out  ADDR_W  data-RAM address; spi_wdata_o  out  32  write word; spi_rdata_i  in  32  SPI interface read mux output.

Function
REQ-012 States SHALL be IDLE, LOAD, CTRL, POLL, READ, DONE.
REQ-013 IDLE: on start_i=1 with len_i≠0, SHALL capture len and clear err_o, then go to LOAD. With len_i=0, SHALL set err_o and stay in IDLE.
REQ-014 LOAD: tx_ready_o=1. Each tx handshake SHALL drive spi_we_o=1, spi_reg_sel_o=1, spi_addr_o=byte index, spi_wdata_o={24'h0,tx_data_i} in the same cycle, then increment the index. After byte len-1 it SHALL go to CTRL.
REQ-015 CTRL: a single cycle with spi_we_o=1 and spi_reg_sel_o=0. spi_wdata_o SHALL be: bit0 send=1, bit1 cs_ctrl=1, bit2 all_1s=0, bit3 all_0s=0, [12:4] n_tx_end=len-1 (zero-extended), [25:16] n_rx=0, others 0. Next state is POLL.
REQ-016 POLL: spi_reg_sel_o=0 and spi_we_o=0. spi_rdata_i[0] SHALL be sampled every cycle except the first POLL cycle, because the control register needs one cycle to update. When send=0, go to READ and reset the index to 0.
REQ-017 POLL SHALL count cycles. When the count reaches TIMEOUT_CYC, set err_o, pulse done_o, and go to IDLE.
REQ-018 READ: spi_reg_sel_o=1 and spi_addr_o=index.
  - The byte at the address SHALL be registered one cycle after the address is presented, then rx_valid_o asserts with rx_data_o = that byte (spi_rdata_i[7:0]).
  - rx_valid_o and rx_data_o SHALL hold stable until rx_ready_i=1.
  - After each handshake the index SHALL advance.
  - After byte len-1 is accepted, go to DONE.
REQ-019 DONE: done_o=1 for exactly one cycle, then IDLE.
REQ-020 spi_we_o SHALL never be 1 outside the LOAD handshake cycles and the CTRL cycle.
REQ-021 start_i while busy_o=1 SHALL be ignored.
REQ-022 busy_o=1 in every state except IDLE.
REQ-023 Index and length counters SHALL be ADDR_W bits wide and SHALL never wrap, since len ≤ 2^ADDR_W-1.
REQ-024 The timeout counter SHALL be $clog2(TIMEOUT_CYC+1) bits wide and saturate at TIMEOUT_CYC.

Reset
REQ-025 rst_i=0 SHALL immediately force:
  - state IDLE;
  - all counters to 0;
  - tx_ready_o, rx_valid_o, busy_o, done_o, err_o, spi_we_o, spi_reg_sel_o = 0;
  - spi_addr_o = 0, spi_wdata_o = 0, rx_data_o = 0.
REQ-026 Reset during any state SHALL abandon the transaction with no further SPI write strobes.

Structure
REQ-027 pkg_global SHALL hold:
  - the state enum type;
  - control-word bit-position constants (SEND_BIT, CS_BIT, ALL1_BIT, ALL0_BIT, NTX_LSB/MSB, NRX_LSB/MSB);
  - the REG_SEL_CTRL/REG_SEL_DATA constants.
REQ-028 SHALL be a single module with no sub-modules. An optional sub-module, module_seq_timeout (saturating counter with clear/enable/expired), is permitted.

Verification
REQ-029 Reset mid-LOAD (after 2 of 4 bytes): assert rst_i=0 -> all outputs 0 in the same cycle; no spi_we_o after release.
REQ-030 len=3, tx bytes A5,3C,FF; SPI model clears send after 20 cycles and returns 11,22,33:
  - three data writes at addr 0,1,2;
  - control write 0x00000023;
  - rx bytes 11,22,33;
  - done_o pulses once; err_o=0.
REQ-031 len=0 with start_i -> err_o=1, busy_o stays 0, no SPI writes.
REQ-032 Send never clears, TIMEOUT_CYC=16 -> err_o=1 and done_o pulse at POLL cycle 16, then return to IDLE.
REQ-033 Backpressure: rx_ready_i=0 for 5 cycles on byte 1 -> rx_data_o stable and spi_addr_o unchanged; resumes correctly.
REQ-034 start_i pulsed during READ -> ignored; the current transaction completes unchanged.
